// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register: valid/ready handshake with a two-entry skid buffer,
// a registered in_ready, synchronous flush with bubble insertion and a saturating drop counter.
module pipe_skid_stage #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 112,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  typedef logic [CNT_W:0] sum_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic                accept;
  logic                pop;
  sum_t                drop_sum;

  assign accept = in_valid & in_ready_q;
  assign pop    = (state_q != S_EMPTY) & out_ready;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: the data/skid storage is cleared on reset too, so out_data reads 0 after reset.
    if (Reset) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    drop_cnt_d  = drop_cnt_q;

    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d     = S_ONE;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept) begin
          state_d     = S_TWO;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          state_d     = S_ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Entries lost to a flush: held ones, plus a coincident accept, minus a coincident pop.
    drop_sum = sum_t'(drop_cnt_q) + sum_t'(state_q) + sum_t'(accept) - sum_t'(pop);
    if (Flush) begin
      state_d     = S_EMPTY;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      drop_cnt_d  = (drop_sum > sum_t'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end

    in_ready_d = (state_d != S_TWO);
  end

  // Outputs.
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    out_ctrl  = out_valid ? main_ctrl_q : '0;
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
